hqm_assertion_ofifo_sched: RTL

Controller for the assertion-side ordered FIFO (ofifo).
- Arbitrates slot reservations among NUM_REQ requesters (round-robin) and drives ofifo `append` to reserve each slot.
- Accepts out-of-order completions and steers them to ofifo `write` by slot address.
- Drains entries in allocation order through a valid/ready output.
- Owns the init/flush sequencing.
- Sits between assertion checkers (requesters/completers) and one ofifo instance.

---
 rtl/hqm_AW_pkg.sv | 29 ++
 rtl/hqm_AW_rr_arb.sv | 57 +++++
 rtl/hqm_assertion_ofifo_sched.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/hqm_AW_pkg.sv
// Shared types and elaboration-time helpers for the assertion-side ofifo scheduler.
//   ofifo_sched_state_t : controller FSM states
//   aw_logb2()          : floor(log2(value)), 0 for value <= 1
//   id_width()          : requester id width for a given requester count
package hqm_AW_pkg;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ofifo_sched_state_t;

  function automatic int unsigned aw_logb2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value;
    r = 0;
    while (v > 1) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int unsigned id_width(input int unsigned num_req);
    return aw_logb2(num_req - 1) + 1;
  endfunction

endpackage

// File: rtl/hqm_AW_rr_arb.sv
// Round-robin arbiter.
//   clk, rst  : clock, asynchronous active-high reset
//   req_i     : per-requester request vector
//   update_i  : advance the priority pointer past the current winner
//   gnt_v_o   : some request is present
//   gnt_id_o  : winning requester, searched upward from the priority pointer
module hqm_AW_rr_arb
  import hqm_AW_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDWIDTH = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               update_i,
  output logic               gnt_v_o,
  output logic [IDWIDTH-1:0] gnt_id_o
);

  logic [IDWIDTH-1:0] ptr_q, ptr_d;
  logic [IDWIDTH-1:0] cand;
  int unsigned        idx;

  always_comb begin
    gnt_v_o  = 1'b0;
    gnt_id_o = '0;
    idx      = 0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // Candidate order ptr, ptr+1, ... modulo NUM_REQ (need not be a power of 2).
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = IDWIDTH'(idx);
      if (!gnt_v_o && req_i[cand]) begin
        gnt_v_o  = 1'b1;
        gnt_id_o = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (update_i && gnt_v_o) begin
      ptr_d = (gnt_id_o == IDWIDTH'(NUM_REQ - 1)) ? '0 : gnt_id_o + IDWIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/hqm_assertion_ofifo_sched.sv
// Controller for the assertion-side ordered FIFO (ofifo).
//   Grant side   : req_v -> gnt_v/gnt_id/gnt_slot, reserves a slot via of_append.
//   Completion   : cmp_v/cmp_slot/cmp_data -> of_write (legal) or err_cmp (illegal).
//   Output side  : out_v/out_data/out_ready, pops the ofifo head in allocation order.
//   Control      : cfg_flush drains then reinitialises; busy whenever not in RUN.
//   ofifo side   : of_init/of_append/of_write/of_pop and pop_v/pop_data from the ofifo.
module hqm_assertion_ofifo_sched
  import hqm_AW_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DWIDTH     = 16,
  parameter int unsigned AWIDTH     = aw_logb2(DEPTH - 1) + 1,
  parameter int unsigned DEPTHWIDTH = aw_logb2(DEPTH) + 1,
  parameter int unsigned IDWIDTH    = id_width(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_flush,
  input  logic [NUM_REQ-1:0]    req_v,
  output logic                  gnt_v,
  output logic [IDWIDTH-1:0]    gnt_id,
  output logic [AWIDTH-1:0]     gnt_slot,
  input  logic                  cmp_v,
  input  logic [AWIDTH-1:0]     cmp_slot,
  input  logic [DWIDTH-1:0]     cmp_data,
  output logic                  out_v,
  output logic [DWIDTH-1:0]     out_data,
  input  logic                  out_ready,
  output logic [DEPTHWIDTH-1:0] outstanding,
  output logic                  busy,
  output logic                  err_cmp,
  output logic                  of_init,
  output logic [AWIDTH-1:0]     of_init_amount,
  output logic                  of_append,
  output logic [AWIDTH-1:0]     of_append_amount,
  output logic                  of_write,
  output logic [AWIDTH-1:0]     of_write_addr,
  output logic [DWIDTH-1:0]     of_write_data,
  output logic                  of_pop,
  input  logic                  of_pop_v,
  input  logic [DWIDTH-1:0]     of_pop_data
);

  ofifo_sched_state_t    state_q, state_d;
  logic [AWIDTH-1:0]     alloc_q, alloc_d;
  logic [AWIDTH-1:0]     head_q, head_d;
  logic [DEPTHWIDTH-1:0] outst_q, outst_d;
  logic [DEPTH-1:0]      written_q, written_d;
  logic                  err_q, err_d;

  logic                  arb_gnt_v;
  logic [IDWIDTH-1:0]    arb_gnt_id;
  logic                  grant_ok;
  logic [AWIDTH-1:0]     slot_off;
  logic                  in_range;
  logic                  cmp_legal;

  // Grants only in RUN with a free slot; the arbiter pointer moves only on a real grant.
  assign grant_ok = (state_q == RUN) && (outst_q < DEPTHWIDTH'(DEPTH));
  assign gnt_v    = arb_gnt_v & grant_ok;
  assign gnt_id   = gnt_v ? arb_gnt_id : '0;
  assign gnt_slot = alloc_q;

  hqm_AW_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDWIDTH (IDWIDTH)
  ) u_rr_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_v),
    .update_i (gnt_v),
    .gnt_v_o  (arb_gnt_v),
    .gnt_id_o (arb_gnt_id)
  );

  // Distance from head wraps mod DEPTH; allocated slots are exactly offsets < outstanding.
  assign slot_off  = cmp_slot - head_q;
  assign in_range  = (outst_q != '0) && (DEPTHWIDTH'(slot_off) < outst_q);
  assign cmp_legal = cmp_v && (state_q != INIT) && in_range && !written_q[cmp_slot];

  assign of_write      = cmp_legal;
  assign of_write_addr = cmp_slot;
  assign of_write_data = cmp_data;

  assign out_v    = of_pop_v & written_q[head_q] & (state_q != INIT);
  assign out_data = of_pop_data;
  assign of_pop   = out_v & out_ready;

  // Gated by rst so the pulse appears only once reset is released.
  assign of_init          = (state_q == INIT) & ~rst;
  assign of_init_amount   = '0;
  assign of_append        = gnt_v;
  assign of_append_amount = AWIDTH'(1);

  assign outstanding = outst_q;
  assign busy        = (state_q != RUN);
  assign err_cmp     = err_q;

  always_comb begin
    state_d   = state_q;
    alloc_d   = alloc_q;
    head_d    = head_q;
    outst_d   = outst_q;
    written_d = written_q;
    err_d     = cmp_v & ~cmp_legal;

    unique case (state_q)
      INIT: begin
        alloc_d   = '0;
        head_d    = '0;
        outst_d   = '0;
        written_d = '0;
        state_d   = RUN;
      end
      RUN: begin
        if (cfg_flush) state_d = DRAIN;
      end
      DRAIN: begin
        if (outst_q == '0) state_d = INIT;
      end
      default: state_d = INIT;
    endcase

    if (state_q != INIT) begin
      // A legal completion never targets a written head, so set and clear cannot collide.
      if (cmp_legal) written_d[cmp_slot] = 1'b1;
      if (of_pop) begin
        written_d[head_q] = 1'b0;
        head_d            = head_q + AWIDTH'(1);
      end
      if (gnt_v) alloc_d = alloc_q + AWIDTH'(1);
      case ({gnt_v, of_pop})
        2'b10:   outst_d = outst_q + DEPTHWIDTH'(1);
        2'b01:   outst_d = outst_q - DEPTHWIDTH'(1);
        default: outst_d = outst_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= INIT;
      alloc_q   <= '0;
      head_q    <= '0;
      outst_q   <= '0;
      written_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      alloc_q   <= alloc_d;
      head_q    <= head_d;
      outst_q   <= outst_d;
      written_q <= written_d;
      err_q     <= err_d;
    end
  end

endmodule
